// File: rtl/synth_pkg.sv
// Shared synth voice-path types and sizing helpers.
package synth_pkg;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    localparam int unsigned NBITS_DEFAULT = 10;

    // Full-scale level for an nbits-wide amplitude.
    function automatic int unsigned lmax(input int unsigned nbits);
        return (32'd1 << nbits) - 32'd1;
    endfunction

endpackage

// File: rtl/adsr_envelope_if.sv
// Envelope control/status bundle: gate and programmable steps in, level and status out.
interface adsr_envelope_if #(
    parameter int unsigned NBITS = synth_pkg::NBITS_DEFAULT
);
    logic             gate;
    logic [NBITS-1:0] attack_step;
    logic [NBITS-1:0] decay_step;
    logic [NBITS-1:0] sustain_level;
    logic [NBITS-1:0] release_step;
    logic [NBITS-1:0] level;
    logic [2:0]       state;
    logic             active;
    logic             done;

    modport master (
        output gate, attack_step, decay_step, sustain_level, release_step,
        input  level, state, active, done
    );

    modport slave (
        input  gate, attack_step, decay_step, sustain_level, release_step,
        output level, state, active, done
    );
endinterface

// File: rtl/adsr_envelope_tick_gen.sv
// Free-running prescaler: registered one-cycle tick every TICK_DIV clocks.
module tick_gen #(
    parameter int unsigned TICK_DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope FSM and level datapath; gate edges act immediately, level moves on ticks.
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int unsigned NBITS    = NBITS_DEFAULT,
    parameter int unsigned TICK_DIV = 100_000
) (
    input  logic            clk,
    input  logic            rst,
    adsr_envelope_if.slave  bus
);
    localparam logic [NBITS-1:0] LMAX = NBITS'(lmax(NBITS));

    logic tick;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    env_state_t        state_r;
    logic [NBITS-1:0]  level_r;
    logic              gate_q;
    logic              active_r;
    logic              done_r;

    logic              rise;
    logic              fall;
    logic [NBITS:0]    attack_sum;
    logic signed [NBITS:0] decay_diff;
    logic signed [NBITS:0] sustain_ext;
    logic              attack_top;
    logic              decay_floor;
    logic              release_floor;

    assign rise = bus.gate & ~gate_q;
    assign fall = ~bus.gate & gate_q;

    // One extra bit keeps the attack sum and decay difference from wrapping.
    assign attack_sum  = {1'b0, level_r} + {1'b0, bus.attack_step};
    assign decay_diff  = $signed({1'b0, level_r}) - $signed({1'b0, bus.decay_step});
    assign sustain_ext = $signed({1'b0, bus.sustain_level});

    assign attack_top    = (bus.attack_step == '0) || (attack_sum >= {1'b0, LMAX});
    assign decay_floor   = (bus.decay_step == '0) || (decay_diff <= sustain_ext);
    assign release_floor = (bus.release_step == '0) || (level_r <= bus.release_step);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ENV_IDLE;
            level_r  <= '0;
            active_r <= 1'b0;
            done_r   <= 1'b0;
            // Keep sampling through reset so a note held across reset is not a new rise.
            gate_q   <= bus.gate;
        end else begin
            gate_q <= bus.gate;
            done_r <= 1'b0;
            if (rise) begin
                state_r  <= ENV_ATTACK;
                active_r <= 1'b1;
            end else if (fall && (state_r == ENV_ATTACK || state_r == ENV_DECAY ||
                                  state_r == ENV_SUSTAIN)) begin
                state_r <= ENV_RELEASE;
            end else if (tick) begin
                case (state_r)
                    ENV_ATTACK: begin
                        if (attack_top) begin
                            level_r <= LMAX;
                            state_r <= ENV_DECAY;
                        end else begin
                            level_r <= attack_sum[NBITS-1:0];
                        end
                    end
                    ENV_DECAY: begin
                        if (decay_floor) begin
                            level_r <= bus.sustain_level;
                            state_r <= ENV_SUSTAIN;
                        end else begin
                            level_r <= decay_diff[NBITS-1:0];
                        end
                    end
                    ENV_SUSTAIN: level_r <= bus.sustain_level;
                    ENV_RELEASE: begin
                        if (release_floor) begin
                            level_r  <= '0;
                            state_r  <= ENV_IDLE;
                            active_r <= 1'b0;
                            done_r   <= 1'b1;
                        end else begin
                            level_r <= level_r - bus.release_step;
                        end
                    end
                    default: level_r <= '0;
                endcase
            end
        end
    end

    assign bus.level  = level_r;
    assign bus.state  = 3'(state_r);
    assign bus.active = active_r;
    assign bus.done   = done_r;
endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope with a cycle-level arithmetic reference model.
module tb_adsr_envelope;
    localparam int NB = 10;
    localparam int D  = 4;
    localparam int LM = 1023;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adsr_envelope_if #(.NBITS(NB)) bus ();

    adsr_envelope #(.NBITS(NB), .TICK_DIV(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model: plain integer envelope rules, advanced once per clock edge.
    int m_level, m_state, m_done, m_gq, m_n;
    int a, d, s, r;
    bit tk, rz, fl;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_level = 0; m_state = 0; m_done = 0; m_n = 0;
            m_gq = int'(bus.gate);
        end else begin
            tk = (m_n > 0) && (m_n % D == 0);
            rz = bus.gate && (m_gq == 0);
            fl = !bus.gate && (m_gq == 1);
            a = int'(bus.attack_step);  d = int'(bus.decay_step);
            s = int'(bus.sustain_level); r = int'(bus.release_step);
            m_done = 0;
            if (rz) m_state = 1;
            else if (fl && m_state >= 1 && m_state <= 3) m_state = 4;
            else if (tk) begin
                if (m_state == 1) begin
                    if (a == 0 || m_level + a >= LM) begin m_level = LM; m_state = 2; end
                    else m_level = m_level + a;
                end else if (m_state == 2) begin
                    if (d == 0 || m_level - d <= s) begin m_level = s; m_state = 3; end
                    else m_level = m_level - d;
                end else if (m_state == 3) begin
                    m_level = s;
                end else if (m_state == 4) begin
                    if (r == 0 || m_level <= r) begin m_level = 0; m_state = 0; m_done = 1; end
                    else m_level = m_level - r;
                end
            end
            m_gq = int'(bus.gate);
            m_n++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_level",  int'(bus.level),  m_level);
            check("cyc_state",  int'(bus.state),  m_state);
            check("cyc_active", int'(bus.active), (m_state != 0) ? 1 : 0);
            check("cyc_done",   int'(bus.done),   m_done);
        end
    end

    task automatic wait_change(input string name, input int exp);
        int prev;
        prev = int'(bus.level);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (int'(bus.level) != prev) break;
        end
        check(name, int'(bus.level), exp);
    endtask

    task automatic wait_state(input string name, input int exp, input int bound);
        for (int k = 0; k < bound && int'(bus.state) != exp; k++) @(negedge clk);
        check(name, int'(bus.state), exp);
    endtask

    task automatic set_steps(input int at, input int dc, input int su, input int rl);
        bus.attack_step   = NB'(at);
        bus.decay_step    = NB'(dc);
        bus.sustain_level = NB'(su);
        bus.release_step  = NB'(rl);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.gate = 1'b0;
        set_steps(256, 100, 800, 300);
        repeat (3) @(negedge clk);
        check("rst_level",  int'(bus.level),  0);
        check("rst_state",  int'(bus.state),  0);
        check("rst_active", int'(bus.active), 0);
        check("rst_done",   int'(bus.done),   0);
        chk_en = 1'b1;

        // Attack, decay, sustain with live sustain tracking
        rst = 1'b0;
        bus.gate = 1'b1;
        @(negedge clk);
        check("gate_to_attack", int'(bus.state), 1);
        wait_change("atk_256", 256);
        wait_change("atk_512", 512);
        wait_change("atk_768", 768);
        wait_change("atk_1023", 1023);
        check("atk_to_decay", int'(bus.state), 2);
        wait_change("dec_923", 923);
        wait_change("dec_823", 823);
        wait_change("dec_800", 800);
        check("dec_to_sustain", int'(bus.state), 3);
        bus.sustain_level = NB'(780);
        wait_change("sus_live_780", 780);
        bus.sustain_level = NB'(800);
        wait_change("sus_live_800", 800);

        // Release to idle with done pulse
        bus.gate = 1'b0;
        @(negedge clk);
        check("fall_to_release", int'(bus.state), 4);
        wait_change("rel_500", 500);
        wait_change("rel_200", 200);
        wait_change("rel_0", 0);
        check("rel_idle",   int'(bus.state),  0);
        check("rel_done",   int'(bus.done),   1);
        check("rel_active", int'(bus.active), 0);
        @(negedge clk);
        check("done_one_cycle", int'(bus.done), 0);

        // Retrigger from release keeps the current level
        bus.gate = 1'b1;
        wait_state("retrig_reach_sus", 3, 100);
        bus.gate = 1'b0;
        wait_change("retrig_rel_500", 500);
        bus.gate = 1'b1;
        @(negedge clk);
        check("retrig_state", int'(bus.state), 1);
        check("retrig_hold",  int'(bus.level), 500);
        wait_change("retrig_756", 756);
        wait_change("retrig_1012", 1012);
        wait_change("retrig_1023", 1023);

        // Gate rise on the same cycle as a tick
        wait_state("eot_reach_sus", 3, 100);
        bus.gate = 1'b0;
        wait_change("eot_rel_500", 500);
        for (int k = 0; k < 8 && !(m_n > 0 && m_n % D == 0); k++) @(negedge clk);
        bus.gate = 1'b1;
        @(negedge clk);
        check("eot_state", int'(bus.state), 1);
        check("eot_level", int'(bus.level), 500);
        wait_change("eot_756", 756);

        // Zero steps jump straight to their targets
        wait_state("zero_reach_sus", 3, 100);
        set_steps(0, 0, 800, 0);
        bus.gate = 1'b0;
        wait_change("rel0_to_0", 0);
        check("rel0_idle", int'(bus.state), 0);
        check("rel0_done", int'(bus.done), 1);
        bus.gate = 1'b1;
        wait_change("atk0_to_max", 1023);
        check("atk0_decay", int'(bus.state), 2);
        wait_change("dec0_to_sus", 800);
        check("dec0_sustain", int'(bus.state), 3);

        // Reset in the middle of attack
        set_steps(256, 100, 800, 300);
        bus.gate = 1'b0;
        wait_change("pre_rst_500", 500);
        wait_change("pre_rst_200", 200);
        wait_change("pre_rst_0", 0);
        bus.gate = 1'b1;
        wait_change("pre_rst_256", 256);
        wait_change("pre_rst_512", 512);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_level",  int'(bus.level),  0);
        check("midrst_state",  int'(bus.state),  0);
        check("midrst_done",   int'(bus.done),   0);
        check("midrst_active", int'(bus.active), 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("held_gate_idle",  int'(bus.state), 0);
        check("held_gate_level", int'(bus.level), 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
